// File: rtl/mealy_seq_detector.sv
// rtl/mealy_seq_detector.sv - parametrised Mealy sequence detector over one-hot input lines
// Optional build macro: MEALY_REG_OUT_EN (registers z, delaying it by one cycle)
module mealy_seq_detector #(
   parameter int                          NCH     = 2,
   parameter int                          DEPTH   = 4,
   parameter logic [$clog2(NCH)*DEPTH-1:0] PATTERN = 'b0100,
   parameter int                          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   in,
   input  logic             overlap,
   output logic             z,
   output logic             err,
   output logic [CNT_W-1:0] match_count
);

   localparam int SW = $clog2(NCH);
   // history holds DEPTH-1 symbols; keep at least one entry so DEPTH=1 still elaborates
   localparam int HD = (DEPTH > 1) ? DEPTH - 1 : 1;
   localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH - 1);

   logic [SW-1:0]    hist_q [HD];
   logic [SW-1:0]    hist_d [HD];
   logic [FW-1:0]    fill_q, fill_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid, multi, match;
   logic [SW-1:0]    sym;

   // classify the input lines: idle, single valid symbol, or illegal multi-line
   always_comb begin
      sym   = '0;
      valid = (in != '0) && ((in & (in - NCH'(1))) == '0);
      multi = (in != '0) && !valid;
      for (int k = 0; k < NCH; k++) begin
         if (in[k]) sym = SW'(k);
      end
   end

   // match when the incoming symbol completes the pattern against a full history
   always_comb begin
      match = valid && (sym == PATTERN[(DEPTH-1)*SW +: SW]) && (fill_q == FILL_MAX);
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (hist_q[i] != PATTERN[(DEPTH-2-i)*SW +: SW]) match = 1'b0;
      end
   end

   // next-state: shift history, track fill, saturating match counter
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      count_d = count_q;
      if (multi) begin
         for (int i = 0; i < HD; i++) hist_d[i] = '0;
         fill_d = '0;
      end else if (valid) begin
         for (int i = HD - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
         hist_d[0] = sym;
         if (match && !overlap) begin
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
         end
      end
      if (match && (count_q != '1)) count_d = count_q + 1'b1;
   end

   // state registers, asynchronously cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < HD; i++) hist_q[i] <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         count_q <= count_d;
      end
   end

`ifdef MEALY_REG_OUT_EN
   logic z_q, z_d;

   // registered match flag: high for the one cycle after the matching symbol
   always_comb z_d = match;

   // output flop for the delayed match flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) z_q <= 1'b0;
      else       z_q <= z_d;
   end

   assign z = z_q;
`else
   assign z = match && !reset;
`endif

   assign err         = multi && !reset;
   assign match_count = count_q;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb/tb_mealy_seq_detector.sv - directed self-checking bench for mealy_seq_detector
module tb_mealy_seq_detector;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] in_lines = 2'b00;
   logic       overlap = 1'b1;
   logic       z, err, z_sat, err_sat;
   logic [7:0] match_count;
   logic [1:0] count_sat;

   int errors = 0;
   int checks = 0;
   logic prev_exp_z = 1'b0;

   localparam logic [1:0] S0 = 2'b01;
   localparam logic [1:0] S1 = 2'b10;
   localparam logic [1:0] ID = 2'b00;
   localparam logic [1:0] BAD = 2'b11;

   always #5 clk = ~clk;

   mealy_seq_detector #(.NCH(2), .DEPTH(4), .PATTERN(4'b0100), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in(in_lines), .overlap(overlap),
      .z(z), .err(err), .match_count(match_count)
   );

   mealy_seq_detector #(.NCH(2), .DEPTH(4), .PATTERN(4'b0100), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in(in_lines), .overlap(overlap),
      .z(z_sat), .err(err_sat), .match_count(count_sat)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // present one input for one cycle, checking z and err away from the clock edge
   task automatic step(input string tag, input logic [1:0] v, input logic exp_z, input logic exp_err);
      @(negedge clk);
      in_lines = v;
      #1;
`ifdef MEALY_REG_OUT_EN
      chk({tag, ".z"}, {31'd0, z}, {31'd0, prev_exp_z});
`else
      chk({tag, ".z"}, {31'd0, z}, {31'd0, exp_z});
`endif
      chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
      prev_exp_z = exp_z;
   endtask

   task automatic check_count(input string tag, input logic [7:0] exp);
      step({tag, ".idle"}, ID, 1'b0, 1'b0);
      chk({tag, ".count"}, {24'd0, match_count}, {24'd0, exp});
   endtask

   // hold reset over a clock edge with illegal input to confirm output gating
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      in_lines = BAD;
      #1;
      chk({tag, ".rst_z"}, {31'd0, z}, 32'd0);
      chk({tag, ".rst_err"}, {31'd0, err}, 32'd0);
      @(negedge clk);
      #1;
      chk({tag, ".rst_count"}, {24'd0, match_count}, 32'd0);
      reset = 1'b0;
      in_lines = ID;
      prev_exp_z = 1'b0;
   endtask

   initial begin
      // test 1: basic match
      overlap = 1'b1;
      do_reset("t1");
      step("t1.s1", S0, 0, 0);
      step("t1.s2", S0, 0, 0);
      step("t1.s3", S1, 0, 0);
      step("t1.s4", S0, 1, 0);
      check_count("t1", 8'd1);

      // test 2a: overlapping matches
      overlap = 1'b1;
      do_reset("t2a");
      step("t2a.s1", S0, 0, 0);
      step("t2a.s2", S0, 0, 0);
      step("t2a.s3", S1, 0, 0);
      step("t2a.s4", S0, 1, 0);
      step("t2a.s5", S0, 0, 0);
      step("t2a.s6", S1, 0, 0);
      step("t2a.s7", S0, 1, 0);
      check_count("t2a", 8'd2);

      // test 2b: non-overlapping, second occurrence suppressed
      overlap = 1'b0;
      do_reset("t2b");
      step("t2b.s1", S0, 0, 0);
      step("t2b.s2", S0, 0, 0);
      step("t2b.s3", S1, 0, 0);
      step("t2b.s4", S0, 1, 0);
      step("t2b.s5", S0, 0, 0);
      step("t2b.s6", S1, 0, 0);
      step("t2b.s7", S0, 0, 0);
      check_count("t2b", 8'd1);
      overlap = 1'b1;

      // test 3: idle cycles ignored
      do_reset("t3");
      step("t3.s1", S0, 0, 0);
      step("t3.s2", S0, 0, 0);
      step("t3.i1", ID, 0, 0);
      step("t3.i2", ID, 0, 0);
      step("t3.s3", S1, 0, 0);
      step("t3.i3", ID, 0, 0);
      step("t3.s4", S0, 1, 0);
      check_count("t3", 8'd1);

      // test 4: illegal input clears history
      do_reset("t4");
      step("t4.s1", S0, 0, 0);
      step("t4.s2", S0, 0, 0);
      step("t4.s3", S1, 0, 0);
      step("t4.bad", BAD, 0, 1);
      step("t4.s4", S0, 0, 0);
      step("t4.f1", S0, 0, 0);
      step("t4.f2", S1, 0, 0);
      step("t4.f3", S0, 1, 0);
      check_count("t4", 8'd1);

      // test 5: reset mid-sequence discards history
      do_reset("t5");
      step("t5.s1", S0, 0, 0);
      step("t5.s2", S0, 0, 0);
      step("t5.s3", S1, 0, 0);
      do_reset("t5b");
      step("t5.s4", S0, 0, 0);
      check_count("t5", 8'd0);

      // test 6: five overlapping matches, 2-bit counter saturates at 3
      do_reset("t6");
      for (int m = 0; m < 5; m++) begin
         if (m == 0) step("t6.a", S0, 0, 0);
         step("t6.b", S0, 0, 0);
         step("t6.c", S1, 0, 0);
         step("t6.d", S0, 1, 0);
      end
      check_count("t6", 8'd5);
      chk("t6.sat_count", {30'd0, count_sat}, 32'd3);
      chk("t6.sat_err", {31'd0, err_sat}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
